// File: rtl/axis_ingress_demux.sv
// Purpose: AXI-Stream ingress fork; beat 0 goes to the parser header slot, every beat goes to the seq-tagged payload slot; runts dropped, oversize packets truncated.
// Latency: 1 cycle from ingress handshake to output valid on both the header and payload ports.
// Backpressure: beat 0 waits until both slots are free; body beats wait only on the payload slot; discarded beats are always accepted.
// Optional: define AXIS_DEMUX_STATS_EN to get live stat_pkts/stat_drops counters (otherwise both ports are tied to 0).
module axis_ingress_demux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MIN_BYTES  = 14,
    parameter int MAX_BEATS  = 32,
    parameter int SEQ_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] hdr_data,
    output logic [SEQ_WIDTH-1:0]  hdr_seq,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [DATA_WIDTH-1:0] m_pay_tdata,
    output logic [KEEP_WIDTH-1:0] m_pay_tkeep,
    output logic                  m_pay_tlast,
    output logic [SEQ_WIDTH:0]    m_pay_tuser,
    output logic                  m_pay_tvalid,
    input  logic                  m_pay_tready,
    output logic [31:0]           stat_pkts,
    output logic [31:0]           stat_drops
);

    localparam int BCW = $clog2(MAX_BEATS + 1);
    localparam int KCW = $clog2(KEEP_WIDTH + 1);
    localparam logic [KCW-1:0] MIN_CNT  = KCW'(MIN_BYTES);
    localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BEATS - 1);

    typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;

    state_t               state;
    logic [SEQ_WIDTH-1:0] seq;
    logic [BCW-1:0]       beat_cnt;
    logic [KCW-1:0]       keep_cnt;
    logic                 is_runt;
    logic                 hslot_free;
    logic                 pslot_free;
    logic                 s_hs;

    // Byte count of the incoming beat; only the popcount matters, so gaps in tkeep are tolerated.
    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + KCW'(s_tkeep[i]);
        end
        is_runt = s_tlast && (keep_cnt < MIN_CNT);
    end

    // Ingress ready: beat 0 needs both slots so a packet is never half-forked.
    always_comb begin
        hslot_free = !hdr_valid || hdr_ready;
        pslot_free = !m_pay_tvalid || m_pay_tready;
        s_tready   = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    s_tready = hslot_free && pslot_free;
                BODY:    s_tready = pslot_free;
                DISCARD: s_tready = 1'b1;
                default: s_tready = 1'b0;
            endcase
        end
        s_hs = s_tvalid && s_tready;
    end

    // Packet FSM with both output slots and the sequence tag held in registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            seq          <= '0;
            beat_cnt     <= '0;
            hdr_data     <= '0;
            hdr_seq      <= '0;
            hdr_valid    <= 1'b0;
            m_pay_tdata  <= '0;
            m_pay_tkeep  <= '0;
            m_pay_tlast  <= 1'b0;
            m_pay_tuser  <= '0;
            m_pay_tvalid <= 1'b0;
`ifdef AXIS_DEMUX_STATS_EN
            stat_pkts    <= '0;
            stat_drops   <= '0;
`endif
        end else begin
            // Drain first; a load below in the same cycle overrides the clear.
            if (hdr_ready)    hdr_valid    <= 1'b0;
            if (m_pay_tready) m_pay_tvalid <= 1'b0;

            case (state)
                IDLE: begin
                    if (s_hs) begin
                        if (is_runt) begin
`ifdef AXIS_DEMUX_STATS_EN
                            stat_drops <= stat_drops + 32'd1;
`endif
                        end else begin
                            hdr_data     <= s_tdata;
                            hdr_seq      <= seq;
                            hdr_valid    <= 1'b1;
                            m_pay_tdata  <= s_tdata;
                            m_pay_tkeep  <= s_tkeep;
                            m_pay_tlast  <= s_tlast;
                            m_pay_tuser  <= {1'b0, seq};
                            m_pay_tvalid <= 1'b1;
                            beat_cnt     <= BCW'(1);
                            if (s_tlast) begin
                                seq <= seq + 1'b1;
`ifdef AXIS_DEMUX_STATS_EN
                                stat_pkts <= stat_pkts + 32'd1;
`endif
                            end else begin
                                state <= BODY;
                            end
                        end
                    end
                end
                BODY: begin
                    if (s_hs) begin
                        m_pay_tdata  <= s_tdata;
                        m_pay_tkeep  <= s_tkeep;
                        m_pay_tlast  <= s_tlast;
                        m_pay_tuser  <= {1'b0, seq};
                        m_pay_tvalid <= 1'b1;
                        beat_cnt     <= beat_cnt + 1'b1;
                        // A genuine tlast on the final allowed beat wins over truncation.
                        if (s_tlast) begin
                            seq   <= seq + 1'b1;
                            state <= IDLE;
`ifdef AXIS_DEMUX_STATS_EN
                            stat_pkts <= stat_pkts + 32'd1;
`endif
                        end else if (beat_cnt == LAST_CNT) begin
                            m_pay_tlast <= 1'b1;
                            m_pay_tuser <= {1'b1, seq};
                            seq         <= seq + 1'b1;
                            state       <= DISCARD;
`ifdef AXIS_DEMUX_STATS_EN
                            stat_pkts  <= stat_pkts + 32'd1;
                            stat_drops <= stat_drops + 32'd1;
`endif
                        end
                    end
                end
                DISCARD: begin
                    if (s_hs && s_tlast) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef AXIS_DEMUX_STATS_EN
    assign stat_pkts  = '0;
    assign stat_drops = '0;
`endif

endmodule

// File: tb/tb_axis_ingress_demux.sv
module tb_axis_ingress_demux;

    localparam int DW   = 512;
    localparam int KW   = 64;
    localparam int SW   = 8;
    localparam int MAXB = 32;
    localparam int MINB = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] hdr_data;
    logic [SW-1:0] hdr_seq;
    logic          hdr_valid;
    logic          hdr_ready;
    logic [DW-1:0] m_pay_tdata;
    logic [KW-1:0] m_pay_tkeep;
    logic          m_pay_tlast;
    logic [SW:0]   m_pay_tuser;
    logic          m_pay_tvalid;
    logic          m_pay_tready;
    logic [31:0]   stat_pkts;
    logic [31:0]   stat_drops;

    always #5 clk = ~clk;

    axis_ingress_demux #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MIN_BYTES(MINB), .MAX_BEATS(MAXB), .SEQ_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .hdr_data(hdr_data), .hdr_seq(hdr_seq), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .m_pay_tdata(m_pay_tdata), .m_pay_tkeep(m_pay_tkeep), .m_pay_tlast(m_pay_tlast),
        .m_pay_tuser(m_pay_tuser), .m_pay_tvalid(m_pay_tvalid), .m_pay_tready(m_pay_tready),
        .stat_pkts(stat_pkts), .stat_drops(stat_drops)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] seq;
    } hdr_exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [SW:0]   user;
    } pay_exp_t;

    hdr_exp_t      hq[$];
    pay_exp_t      pq[$];
    logic [DW-1:0] beats[64];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          mseq     = 0;
    int unsigned m_pkts   = 0;
    int unsigned m_drops  = 0;
    int          n_trunc_seen = 0;
    int          cyc      = 0;
    int          mode     = 0;   // 0: readies high, 1: random readies, 2: payload hold countdown
    int          hold_cnt = 0;

    function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [KW-1:0] keep_n(int n);
        logic [KW-1:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Packet-level reference: decides drop / forward / truncate for a whole packet and
    // queues every output it must produce.
    function automatic void model_push(int len, logic [KW-1:0] last_keep);
        int n;
        if (len == 1 && $countones(last_keep) < MINB) begin
            m_drops++;
            return;
        end
        hq.push_back('{data: beats[0], seq: SW'(mseq)});
        n = (len > MAXB) ? MAXB : len;
        for (int k = 0; k < n; k++) begin
            pay_exp_t e;
            e.data = beats[k];
            e.keep = (k == len - 1) ? last_keep : '1;
            e.last = (k == n - 1);
            e.user = {(len > MAXB) && (k == n - 1), SW'(mseq)};
            pq.push_back(e);
        end
        if (len > MAXB) m_drops++;
        m_pkts++;
        mseq = (mseq + 1) % (1 << SW);
    endfunction

    function automatic void model_reset();
        hq.delete();
        pq.delete();
        mseq    = 0;
        m_pkts  = 0;
        m_drops = 0;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
        case (mode)
            0: begin hdr_ready = 1'b1; m_pay_tready = 1'b1; end
            1: begin
                hdr_ready    = ($urandom_range(3) != 0);
                m_pay_tready = ($urandom_range(3) != 0);
            end
            2: begin
                hdr_ready    = 1'b1;
                m_pay_tready = (hold_cnt == 0);
                if (hold_cnt > 0) hold_cnt--;
            end
            default: ;
        endcase
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Present one beat, wait (bounded) for acceptance, return at the negedge after the handshake.
    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             output int waited);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        waited   = 0;
        #1;
        while (!s_tready) begin
            if (waited >= 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL s_tready_timeout: got no handshake in %0d cycles expected acceptance", waited);
                summary();
                $fatal(1, "stalled ingress");
            end
            tick();
            #1;
            waited++;
        end
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic check_stats();
`ifdef AXIS_DEMUX_STATS_EN
        check("stat_pkts", DW'(stat_pkts), DW'(m_pkts));
        check("stat_drops", DW'(stat_drops), DW'(m_drops));
`else
        check("stat_pkts", DW'(stat_pkts), DW'(0));
        check("stat_drops", DW'(stat_drops), DW'(0));
`endif
    endtask

    task automatic send_pkt(input int len, input logic [KW-1:0] last_keep, input bit gaps);
        int w;
        for (int k = 0; k < len; k++) beats[k] = rand_data();
        model_push(len, last_keep);
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(3) == 0) tick();
            send_beat(beats[k], (k == len - 1) ? last_keep : '1, (k == len - 1), w);
        end
        check_stats();
    endtask

    // Compare process: while a slot is valid its contents must equal the head of the
    // expected queue (this also proves data is held stable); pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst !== 1'b0) continue;
            if (hdr_valid) begin
                if (hq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL hdr_spurious: got hdr_valid=1 expected 0");
                end else begin
                    check("hdr_data", hdr_data, hq[0].data);
                    check("hdr_seq", DW'(hdr_seq), DW'(hq[0].seq));
                    if (hdr_ready) void'(hq.pop_front());
                end
            end
            if (m_pay_tvalid) begin
                if (pq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pay_spurious: got m_pay_tvalid=1 expected 0");
                end else begin
                    check("pay_tdata", m_pay_tdata, pq[0].data);
                    check("pay_ctl", DW'({m_pay_tkeep, m_pay_tlast, m_pay_tuser}),
                          DW'({pq[0].keep, pq[0].last, pq[0].user}));
                    if (m_pay_tready) begin
                        if (m_pay_tuser[SW]) n_trunc_seen++;
                        void'(pq.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #3ms;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got no finish by 3ms expected completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int t0;
        int stalls;
        rst = 1'b1;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        hdr_ready = 1'b1; m_pay_tready = 1'b1;
        tick();
        tick();
        check("rst_s_tready", DW'(s_tready), DW'(0));
        check("rst_hdr_valid", DW'(hdr_valid), DW'(0));
        check("rst_pay_valid", DW'(m_pay_tvalid), DW'(0));
        check("rst_hdr_data", hdr_data, DW'(0));
        check("rst_pay_user", DW'(m_pay_tuser), DW'(0));
        check_stats();
        rst = 1'b0;
        tick();

        // Runt: 12 bytes single beat, dropped without consuming a seq
        beats[0] = rand_data();
        model_push(1, keep_n(12));
        send_beat(beats[0], keep_n(12), 1'b1, w);
        tick();
        check("runt_hdr_valid", DW'(hdr_valid), DW'(0));
        check("runt_pay_valid", DW'(m_pay_tvalid), DW'(0));
`ifdef AXIS_DEMUX_STATS_EN
        check("runt_stat_drops", DW'(stat_drops), DW'(1));
`endif
        check_stats();

        // Single 64-byte beat: both ports fire next cycle with seq 0
        beats[0] = rand_data();
        model_push(1, '1);
        send_beat(beats[0], '1, 1'b1, w);
        check("b1_hdr_valid", DW'(hdr_valid), DW'(1));
        check("b1_pay_valid", DW'(m_pay_tvalid), DW'(1));
        check("b1_pay_tlast", DW'(m_pay_tlast), DW'(1));
        check("b1_pay_tuser", DW'(m_pay_tuser), DW'(9'h000));
        check("b1_hdr_seq", DW'(hdr_seq), DW'(0));
        check("b1_hdr_data", hdr_data, beats[0]);
`ifdef AXIS_DEMUX_STATS_EN
        check("b1_stat_pkts", DW'(stat_pkts), DW'(1));
`endif

        // 3 beats with the payload port stalled for 4 cycles after beat 0
        for (int k = 0; k < 3; k++) beats[k] = rand_data();
        model_push(3, '1);
        send_beat(beats[0], '1, 1'b0, w);
        mode = 2;
        hold_cnt = 3;
        m_pay_tready = 1'b0;
        send_beat(beats[1], '1, 1'b0, w);
        check("body_stall_cycles", DW'(w), DW'(4));
        send_beat(beats[2], '1, 1'b1, w);
        mode = 0;
        check_stats();
        tick();

        // 40 beats: 32 emitted, the 32nd flagged and terminated, the rest swallowed
        send_pkt(40, '1, 1'b0);
        tick();
        tick();
        check("trunc_beats_seen", DW'(n_trunc_seen), DW'(1));
`ifdef AXIS_DEMUX_STATS_EN
        check("trunc_stat_drops", DW'(stat_drops), DW'(2));
`endif
        beats[0] = rand_data();
        model_push(1, '1);
        send_beat(beats[0], '1, 1'b1, w);
        check("post_trunc_seq", DW'(hdr_seq), DW'(3));

        // Exactly MAX_BEATS with a real tlast is not truncated
        send_pkt(MAXB, keep_n(5), 1'b0);
        tick();
        tick();
        check("exact_max_no_trunc", DW'(n_trunc_seen), DW'(1));

        // 257 back-to-back single-beat packets after reset: seq wraps, one per clock
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        t0 = cyc;
        stalls = 0;
        for (int p = 0; p < 257; p++) begin
            beats[0] = rand_data();
            model_push(1, '1);
            send_beat(beats[0], '1, 1'b1, w);
            if (w != 0) stalls++;
            if (p == 0)   check("b2b_first_seq", DW'(hdr_seq), DW'(0));
            if (p == 255) check("b2b_seq_255", DW'(hdr_seq), DW'(255));
            if (p == 256) check("b2b_wrap_seq", DW'(hdr_seq), DW'(0));
        end
        check("b2b_stalls", DW'(stalls), DW'(0));
        check("b2b_cycles", DW'(cyc - t0), DW'(257));
        check_stats();

        // Reset while in the body of a 5-beat packet after 3 beats
        for (int k = 0; k < 5; k++) beats[k] = rand_data();
        model_push(5, '1);
        for (int k = 0; k < 3; k++) send_beat(beats[k], '1, 1'b0, w);
        rst = 1'b1;
        model_reset();
        tick();
        check("midrst_hdr_valid", DW'(hdr_valid), DW'(0));
        check("midrst_pay_valid", DW'(m_pay_tvalid), DW'(0));
        check("midrst_s_tready", DW'(s_tready), DW'(0));
        rst = 1'b0;
        beats[0] = rand_data();
        model_push(1, '1);
        send_beat(beats[0], '1, 1'b1, w);
        check("midrst_hdr_v2", DW'(hdr_valid), DW'(1));
        check("midrst_pay_v2", DW'(m_pay_tvalid), DW'(1));
        check("midrst_seq", DW'(hdr_seq), DW'(0));
        check("midrst_pay_user", DW'(m_pay_tuser), DW'(0));
        check_stats();

        // Random traffic with random backpressure, runts, truncation and idle gaps
        mode = 1;
        for (int p = 0; p < 150; p++) begin
            int len;
            int r;
            r = $urandom_range(9);
            if (r < 3)       len = 1;
            else if (r == 3) len = $urandom_range(MAXB - 1, MAXB + 2);
            else             len = $urandom_range(2, 40);
            send_pkt(len, keep_n($urandom_range(1, KW)), 1'b1);
        end
        mode = 0;
        repeat (10) tick();
        check("drain_hdr_q", DW'(hq.size()), DW'(0));
        check("drain_pay_q", DW'(pq.size()), DW'(0));
        check_stats();

        summary();
        $finish;
    end

endmodule

// File: doc/axis_ingress_demux.md
Name: axis_ingress_demux

Overview:
AXI-Stream slave front end that sits directly upstream of the header parse pipeline and the payload FIFO. Each incoming packet is forked as follows:
- The first beat goes to the parser header port.
- The full packet, including beat 0, goes to the payload store path, tagged with a sequence number so the downstream aligner can re-pair metadata with payload.
- Runt packets are dropped and oversize packets are truncated.

Parameters:
- DATA_WIDTH, 512, tdata width in bits (multiple of 8).
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- MIN_BYTES, 14, minimum valid packet length in bytes (Ethernet header).
- MAX_BEATS, 32, maximum beats per packet before truncation (>=2).
- SEQ_WIDTH, 8, packet sequence tag width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_tdata  in  DATA_WIDTH  ingress data.
- s_tkeep  in  KEEP_WIDTH  ingress byte enables (contiguous from bit 0).
- s_tlast  in  1  ingress end of packet.
- s_tvalid  in  1  ingress valid.
- s_tready  out  1  ingress ready.
- hdr_data  out  DATA_WIDTH  beat 0 of packet, to parser.
- hdr_seq  out  SEQ_WIDTH  sequence tag of header.
- hdr_valid  out  1  header valid.
- hdr_ready  in  1  parser ready.
- m_pay_tdata  out  DATA_WIDTH  payload beat.
- m_pay_tkeep  out  KEEP_WIDTH  payload byte enables.
- m_pay_tlast  out  1  payload end of packet.
- m_pay_tuser  out  SEQ_WIDTH+1  {trunc_err, seq}.
- m_pay_tvalid  out  1  payload valid.
- m_pay_tready  in  1  payload FIFO ready.
- stat_pkts  out  32  accepted packet count (feature-gated).
- stat_drops  out  32  runt plus truncated packet count (feature-gated).

Behaviour:
- Single clock domain. Reset is synchronous and active-high on rst; all state is cleared on a clk edge with rst=1.
- Reset values: s_tready=0 during reset; hdr_valid=0; m_pay_tvalid=0; all data outputs 0; seq=0; beat_cnt=0; state=IDLE; stats=0.
- Both outputs are single registered slots. Latency is 1 cycle from ingress handshake to output valid. Each output's valid is held, with data stable, until its ready is seen.
- hslot_free = !hdr_valid || hdr_ready. pslot_free = !m_pay_tvalid || m_pay_tready.
- FSM states:
  - IDLE (awaiting beat 0):
    - s_tready = hslot_free && pslot_free.
    - On handshake, runt check: runt = s_tlast && popcount(s_tkeep) < MIN_BYTES.
    - Runt: beat consumed, nothing emitted, seq not advanced, drops+1, stay IDLE.
    - Otherwise: load the header slot (hdr_data=s_tdata, hdr_seq=seq) and load the payload slot (tuser={0,seq}, tkeep and tlast passed through). beat_cnt=1.
    - If s_tlast: seq+1, pkts+1, stay IDLE. Otherwise go to BODY.
  - BODY:
    - s_tready = pslot_free. The header slot is untouched.
    - Each handshake loads the payload slot with tuser={0,seq} and increments beat_cnt.
    - If s_tlast: seq+1, pkts+1, go to IDLE.
    - Else if beat_cnt+1 == MAX_BEATS: emit the beat with tlast forced to 1 and tuser={1,seq}; seq+1, drops+1, go to DISCARD.
  - DISCARD:
    - s_tready = 1. Beats are consumed and nothing is emitted.
    - On s_tlast, go to IDLE.
- seq wraps from 2^SEQ_WIDTH-1 to 0 with no stall. Header and payload of the same packet always carry the same seq.
- Beat 0 is never split: it is accepted only when both slots can take it in the same cycle, so no partial fork ever occurs.
- A packet of exactly MAX_BEATS beats whose last beat has tlast=1 is NOT truncated; the tlast check has priority.
- Simultaneous events: a slot may be drained (ready=1) and reloaded in the same cycle, giving full throughput with 1 beat per clk while downstream is ready.
- tkeep is passed through unmodified. A non-contiguous tkeep is undefined input; only the popcount is used.
- Reset mid-packet: partial output is abandoned, valids drop on the next edge, and the first beat after reset is treated as beat 0.
- beat_cnt width is $clog2(MAX_BEATS+1). Stats counters are 32-bit and wrap.

Optional Feature:
- Macro: AXIS_DEMUX_STATS_EN.
- Defined: stat_pkts and stat_drops are live 32-bit counters as above. pkts counts fully delivered or truncated packets, i.e. every packet that emits beats.
- Undefined: the counters are not instantiated and both ports are driven constant 0. All other behaviour is identical.

Test Plan:
- 1-beat 64-byte packet (tkeep all ones, tlast=1), both readies=1 -> next cycle hdr_valid=1 and m_pay_tvalid=1, tlast=1, tuser=0x000, hdr_seq=0; stat_pkts=1.
- 3-beat packet with m_pay_tready=0 for 4 cycles after beat 0 -> s_tready=0 in BODY while the payload slot is full; beat 0 data is held stable; all 3 beats are delivered in order; the header is emitted once.
- Runt: 1 beat, tlast=1, tkeep=0x0FFF (12 bytes) -> no outputs, stat_drops=1; the next packet carries seq=0.
- 40-beat packet with MAX_BEATS=32 -> 32 beats emitted, beat 32 has tlast=1 and tuser[8]=1; beats 33-40 are consumed silently; stat_drops=1; the next packet has seq+1.
- 256 back-to-back 1-beat packets -> hdr_seq runs 0..255 and packet 257 carries seq=0; throughput is 1 packet per clk with readies=1.
- rst asserted in BODY of a 5-beat packet after beat 2 -> all valids are 0 the next cycle; a following 1-beat packet emits on both ports with seq=0.
